// File: rtl/btn_ctrl_if.sv
// Configuration command channel from btn_ctrl to its consumers.
// Carries the valid/ready handshake, the command code and the live
// offset/routing configuration.
//   cfg_valid   : command presented (driven by master)
//   cfg_ready   : consumer accepts the command (driven by slave)
//   cfg_cmd     : 0=HS, 1=VS, 2=DF_UART, 3=DF_VGA
//   cfg_hs_ofs  : horizontal offset register
//   cfg_vs_ofs  : vertical offset register
//   route_uart  : UART data-flow enable
//   route_vga   : VGA data-flow enable
interface btn_ctrl_if #(
    parameter int unsigned OFS_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_cmd;
    logic [OFS_W-1:0] cfg_hs_ofs;
    logic [OFS_W-1:0] cfg_vs_ofs;
    logic             route_uart;
    logic             route_vga;

    modport master (
        output cfg_valid, cfg_cmd, cfg_hs_ofs, cfg_vs_ofs, route_uart, route_vga,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_cmd, cfg_hs_ofs, cfg_vs_ofs, route_uart, route_vga,
        output cfg_ready
    );
endinterface

// File: rtl/btn_ctrl.sv
// Button command controller: detects rising edges on four debounced
// button levels, latches presses, arbitrates them by fixed priority
// (DF_UART > DF_VGA > HS > VS), updates offset/routing config and
// announces each accepted press over a valid/ready handshake followed
// by a lockout window.
//   clk      : system clock
//   rst_n    : synchronous reset, active-high
//   HS, VS, DF_UART, DF_VGA : debounced button levels
//   cfg      : command/config channel (master side)
//   busy     : high whenever the controller is not idle
module btn_ctrl #(
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OFS_W          = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HS,
    input  logic        VS,
    input  logic        DF_UART,
    input  logic        DF_VGA,
    btn_ctrl_if.master  cfg,
    output logic        busy
);

    localparam int unsigned CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int unsigned NBTN  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NBTN-1:0]     lvl, prev_q, pend_q, pend_d, rise, pend_clr;
    logic                armed_q;
    logic [1:0]          sel;
    logic [1:0]          cmd_d;
    logic [OFS_W-1:0]    hs_d, vs_d;
    logic                uart_d, vga_d, valid_d, busy_d;

    // Bit index equals the command code
    assign lvl = {DF_VGA, DF_UART, VS, HS};

    // Next-state, pending and config update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_clr = '0;
        cmd_d    = cfg.cfg_cmd;
        hs_d     = cfg.cfg_hs_ofs;
        vs_d     = cfg.cfg_vs_ofs;
        uart_d   = cfg.route_uart;
        vga_d    = cfg.route_vga;
        sel      = 2'd1;

        // First cycle after reset only primes prev, so held levels are not rises
        rise = armed_q ? (lvl & ~prev_q) : '0;

        if (pend_q[2])      sel = 2'd2;
        else if (pend_q[3]) sel = 2'd3;
        else if (pend_q[0]) sel = 2'd0;
        else                sel = 2'd1;

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    pend_clr[sel] = 1'b1;
                    cmd_d         = sel;
                    case (sel)
                        2'd0:    hs_d   = hs_d + OFS_W'(1);
                        2'd1:    vs_d   = vs_d + OFS_W'(1);
                        2'd2:    uart_d = ~uart_d;
                        default: vga_d  = ~vga_d;
                    endcase
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cfg.cfg_ready) begin
                    cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A rise on the same cycle as the clear keeps the latch set
        pend_d  = (pend_q & ~pend_clr) | rise;
        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            prev_q         <= '0;
            pend_q         <= '0;
            armed_q        <= 1'b0;
            cfg.cfg_valid  <= 1'b0;
            cfg.cfg_cmd    <= 2'd0;
            cfg.cfg_hs_ofs <= '0;
            cfg.cfg_vs_ofs <= '0;
            cfg.route_uart <= 1'b0;
            cfg.route_vga  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_q         <= lvl;
            pend_q         <= pend_d;
            armed_q        <= 1'b1;
            cfg.cfg_valid  <= valid_d;
            cfg.cfg_cmd    <= cmd_d;
            cfg.cfg_hs_ofs <= hs_d;
            cfg.cfg_vs_ofs <= vs_d;
            cfg.route_uart <= uart_d;
            cfg.route_vga  <= vga_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with LOCKOUT_CYCLES=16, OFS_W=4.
module tb_btn_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic HS, VS, DF_UART, DF_VGA;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;
    int   vcnt, bcnt, npulse;
    int   idx [4];
    int   cmds [4];

    btn_ctrl_if #(.OFS_W(4)) bif ();

    btn_ctrl #(.LOCKOUT_CYCLES(16), .OFS_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .HS      (HS),
        .VS      (VS),
        .DF_UART (DF_UART),
        .DF_VGA  (DF_VGA),
        .cfg     (bif.master),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b1;
        HS      = 1'b0;
        VS      = 1'b0;
        DF_UART = 1'b0;
        DF_VGA  = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    // Bounded wait for cfg_valid; returns ticks taken
    task automatic wait_valid(input string tag, output int cnt);
        cnt = 0;
        while (bif.cfg_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(tag, 32'(bif.cfg_valid), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bif.cfg_valid), 32'd0);
        chk({tag, "_cmd"},   32'(bif.cfg_cmd), 32'd0);
        chk({tag, "_hs"},    32'(bif.cfg_hs_ofs), 32'd0);
        chk({tag, "_vs"},    32'(bif.cfg_vs_ofs), 32'd0);
        chk({tag, "_ru"},    32'(bif.route_uart), 32'd0);
        chk({tag, "_rv"},    32'(bif.route_vga), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        bif.cfg_ready = 1'b1;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(bif.cfg_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        chk_all_zero("idle");

        // Single HS press, ready tied high
        HS = 1'b1;
        wait_valid("hs_to", n);
        chk("hs_latency", 32'(n), 32'd2);
        chk("hs_cmd", 32'(bif.cfg_cmd), 32'd0);
        chk("hs_ofs", 32'(bif.cfg_hs_ofs), 32'd1);
        vcnt = 1;
        bcnt = 1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (bif.cfg_valid === 1'b1) vcnt++;
            if (busy === 1'b1) bcnt++;
        end
        chk("hs_pulses", 32'(vcnt), 32'd1);
        chk("hs_busy_len", 32'(bcnt), 32'd17);
        HS = 1'b0;
        tick();

        // Simultaneous press of all four
        do_reset();
        tick();
        HS = 1'b1; VS = 1'b1; DF_UART = 1'b1; DF_VGA = 1'b1;
        npulse = 0;
        for (int i = 1; i <= 75; i++) begin
            tick();
            if (bif.cfg_valid === 1'b1) begin
                if (npulse < 4) begin
                    idx[npulse]  = i;
                    cmds[npulse] = int'(bif.cfg_cmd);
                end
                npulse++;
            end
        end
        chk("sim_npulse", 32'(npulse), 32'd4);
        chk("sim_cmd0", 32'(cmds[0]), 32'd2);
        chk("sim_cmd1", 32'(cmds[1]), 32'd3);
        chk("sim_cmd2", 32'(cmds[2]), 32'd0);
        chk("sim_cmd3", 32'(cmds[3]), 32'd1);
        chk("sim_idx0", 32'(idx[0]), 32'd2);
        chk("sim_gap1", 32'(idx[1] - idx[0]), 32'd18);
        chk("sim_gap2", 32'(idx[2] - idx[1]), 32'd18);
        chk("sim_gap3", 32'(idx[3] - idx[2]), 32'd18);
        chk("sim_ru", 32'(bif.route_uart), 32'd1);
        chk("sim_rv", 32'(bif.route_vga), 32'd1);
        chk("sim_hs", 32'(bif.cfg_hs_ofs), 32'd1);
        chk("sim_vs", 32'(bif.cfg_vs_ofs), 32'd1);
        chk("sim_busy", 32'(busy), 32'd0);

        // Backpressure with a VS press during the stall
        do_reset();
        tick();
        bif.cfg_ready = 1'b0;
        DF_VGA = 1'b1;
        wait_valid("bp_to", n);
        for (int i = 0; i < 8; i++) begin
            chk("bp_valid", 32'(bif.cfg_valid), 32'd1);
            chk("bp_cmd", 32'(bif.cfg_cmd), 32'd3);
            chk("bp_vs_stable", 32'(bif.cfg_vs_ofs), 32'd0);
            chk("bp_rv", 32'(bif.route_vga), 32'd1);
            if (i == 2) VS = 1'b1;
            if (i == 4) VS = 1'b0;
            if (i == 7) bif.cfg_ready = 1'b1;
            tick();
        end
        chk("bp_drop", 32'(bif.cfg_valid), 32'd0);
        chk("bp_lock_busy", 32'(busy), 32'd1);
        wait_valid("bp_vs_to", n);
        chk("bp_vs_wait", 32'(n), 32'd17);
        chk("bp_vs_cmd", 32'(bif.cfg_cmd), 32'd1);
        chk("bp_vs_ofs", 32'(bif.cfg_vs_ofs), 32'd1);
        DF_VGA = 1'b0;
        repeat (20) tick();

        // Offset wrap and route toggle back
        do_reset();
        tick();
        for (int i = 1; i <= 16; i++) begin
            VS = 1'b1;
            tick();
            VS = 1'b0;
            wait_valid("wrap_to", n);
            chk("wrap_vs", 32'(bif.cfg_vs_ofs), 32'(i % 16));
            repeat (20) tick();
        end
        DF_UART = 1'b1;
        tick();
        DF_UART = 1'b0;
        wait_valid("ru1_to", n);
        chk("ru_first", 32'(bif.route_uart), 32'd1);
        repeat (20) tick();
        DF_UART = 1'b1;
        tick();
        DF_UART = 1'b0;
        wait_valid("ru2_to", n);
        chk("ru_second", 32'(bif.route_uart), 32'd0);
        repeat (20) tick();

        // Reset in LOCK with DF_VGA pending and HS held high
        do_reset();
        tick();
        DF_UART = 1'b1;
        wait_valid("mr_to", n);
        chk("mr_cmd", 32'(bif.cfg_cmd), 32'd2);
        DF_UART = 1'b0;
        DF_VGA  = 1'b1;
        HS      = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_ru", 32'(bif.route_uart), 32'd1);
        DF_VGA = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk_all_zero("mr_rst");
        rst_n = 1'b0;
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bif.cfg_valid === 1'b1) vcnt++;
            if (busy === 1'b1) bcnt++;
        end
        chk("mr_no_issue", 32'(vcnt), 32'd0);
        chk("mr_no_busy", 32'(bcnt), 32'd0);
        HS = 1'b0;
        tick();
        HS = 1'b1;
        wait_valid("mr_hs_to", n);
        chk("mr_hs_lat", 32'(n), 32'd2);
        chk("mr_hs_cmd", 32'(bif.cfg_cmd), 32'd0);
        chk("mr_hs_ofs", 32'(bif.cfg_hs_ofs), 32'd1);
        chk("mr_hs_ru", 32'(bif.route_uart), 32'd0);
        chk("mr_hs_rv", 32'(bif.route_vga), 32'd0);
        HS = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
